store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered store entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port st_valid, input, 1 bit, meaning the MEM stage presents a word store this cycle.
REQ-005 The block SHALL have port st_addr, input, 32 bits, the store byte address (bits [1:0] ignored).
REQ-006 The block SHALL have port st_data, input, 32 bits, the store data.
REQ-007 The block SHALL have port ld_valid, input, 1 bit, meaning the MEM stage presents a word load this cycle.
REQ-008 The block SHALL have port ld_addr, input, 32 bits, the load byte address (bits [1:0] ignored).
REQ-009 The block SHALL have port ld_data, output, 32 bits, the load result (combinational).
REQ-010 The block SHALL have port stall, output, 1 bit, meaning the buffer is full and the store must be held.
REQ-011 The block SHALL have port empty, output, 1 bit, meaning no entries are buffered.
REQ-012 The block SHALL have port dm_we, output, 1 bit, driving the data memory memWrite.
REQ-013 The block SHALL have port dm_addr, output, 32 bits, driving the data memory memAddr.
REQ-014 The block SHALL have port dm_wdata, output, 32 bits, driving the data memory writeData.
REQ-015 The block SHALL have port dm_rdata, input, 32 bits, taking the data memory readData (combinational, word-addressed).

Function
REQ-016 The buffer SHALL be a circular FIFO of DEPTH entries {word address [31:2], data}, with head/tail pointers wrapping modulo DEPTH and a count from 0 to DEPTH.
REQ-017 Outputs stall and empty SHALL be defined as stall = (count == DEPTH) and empty = (count == 0), both combinational from the registered count.
REQ-018 A push SHALL occur at the clock edge when st_valid=1 and stall=0; st_valid while stall=1 SHALL be ignored (the upstream holds the store).
REQ-019 The data memory port SHALL be owned by loads with priority: when ld_valid=1, the block SHALL drive dm_addr=ld_addr and dm_we=0.
REQ-020 When ld_valid=0 and empty=0, the block SHALL drain: dm_we=1, dm_addr={head addr, 2'b00}, dm_wdata=head data, and the head SHALL pop at that edge.
REQ-021 When ld_valid=0 and empty=1, the block SHALL drive dm_we=0, dm_addr=0, and dm_wdata=0.
REQ-022 Simultaneous push and drain SHALL leave count unchanged and SHALL advance both pointers; a push while full SHALL be refused even if a drain occurs in the same cycle.
REQ-023 ld_data SHALL equal the data of the youngest buffered entry whose word address equals ld_addr[31:2]; if none matches, ld_data SHALL equal dm_rdata.
REQ-024 A store pushed in the same cycle as a load SHALL NOT forward to that load; it SHALL be visible to loads from the next cycle.
REQ-025 When ld_valid=0, ld_data SHALL still follow REQ-023 (don't-care to the consumer, but deterministic).
REQ-026 Store order to the data memory SHALL equal push order; multiple entries to the same address SHALL all drain in order (no merging).
REQ-027 Drain latency SHALL be as follows: an entry pushed into an empty buffer with ld_valid=0 on the next cycle SHALL be written to the data memory at the edge after its push edge (one cycle of residence).

Reset
REQ-028 On a clock edge with reset=1, the block SHALL set count=0 and head=tail=0 and discard all entries, including a same-cycle push, with no dm write on that edge.
REQ-029 After reset, the outputs SHALL be stall=0, empty=1, dm_we=0, dm_addr=0 (absent ld_valid), and dm_wdata=0.
REQ-030 Entry payload registers SHALL NOT require a reset; valid state is carried by count only.

Verification
REQ-031 Scenario: reset, then st 0x10/0xAAAA0001 with ld_valid=0 -> next cycle dm_we=1, dm_addr=0x10, dm_wdata=0xAAAA0001; the following cycle empty=1.
REQ-032 Scenario: hold ld_valid=1 (addr 0x40) and push 4 stores -> stall=1 after the 4th; a 5th st_valid is ignored; dm_we stays 0 throughout.
REQ-033 Scenario: buffer holds 0x20/0x1, then 0x20/0x2; ld 0x22 -> ld_data=0x2 (youngest, low bits ignored); ld 0x24 -> ld_data=dm_rdata.
REQ-034 Scenario: same-cycle st 0x30/0x5 and ld 0x30 with an empty buffer -> ld_data=dm_rdata (old value); a ld 0x30 on the next cycle -> 0x5.
REQ-035 Scenario: full buffer, ld_valid=0, st_valid=1 -> head drains and the push is refused; the next cycle push is accepted; pointers wrap with order preserved over 10 stores.
REQ-036 Scenario: 3 entries buffered, reset asserted for one cycle while st_valid=1 -> empty=1, no dm_we during or after, and a later load returns dm_rdata.

Source files
------------

// File: rtl/store_buffer.sv
// Word store buffer: circular FIFO of pending stores with youngest-match load forwarding; drains one entry per cycle when no load owns memory.
// Latency: a buffered store is written to memory at the first edge with no load, one cycle after its push at the earliest; stall asserts when full.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic [31:0] ld_data,
   output logic        stall,
   output logic        empty,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef logic [AW-1:0] ptr_t;

   logic [29:0] ent_addr [DEPTH];
   logic [31:0] ent_data [DEPTH];
   ptr_t        head;
   ptr_t        tail;
   logic [AW:0] count;
   logic        push;
   logic        drain;
   ptr_t        fwd_idx;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

   assign stall = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign push  = st_valid && !stall;
   assign drain = !ld_valid && !empty && !reset;

   // Loads own the memory port; otherwise the head entry is written out.
   always_comb begin
      dm_we    = 1'b0;
      dm_addr  = 32'h0;
      dm_wdata = 32'h0;
      if (ld_valid) begin
         dm_addr = ld_addr;
      end else if (drain) begin
         dm_we    = 1'b1;
         dm_addr  = {ent_addr[head], 2'b00};
         dm_wdata = ent_data[head];
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      fwd_idx  = head;
      fwd_hit  = 1'b0;
      fwd_data = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head + ptr_t'(i);
         if (((AW+1)'(i) < count) && (ent_addr[fwd_idx] == ld_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[fwd_idx];
         end
      end
      ld_data = fwd_hit ? fwd_data : dm_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + ptr_t'(1);
         if (drain)
            head <= head + ptr_t'(1);
         case ({push, drain})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         ent_addr[tail] <= st_addr[31:2];
         ent_data[tail] <= st_data;
      end
   end

endmodule
